// File: rtl/fp_cmp_pkg.sv
// Shared constants and the ">= 0" decode used by the floating-point compare arbiter.
package fp_cmp_pkg;

    // FloPoCo 11/52 operand: {exn[1:0], sign, exponent[10:0], fraction[51:0]}
    localparam int FP_W = 66;

    // FloPoCo exception field encodings
    localparam logic [1:0] EXN_ZERO   = 2'b00;
    localparam logic [1:0] EXN_NORMAL = 2'b01;
    localparam logic [1:0] EXN_INF    = 2'b10;
    localparam logic [1:0] EXN_NAN    = 2'b11;

    typedef struct packed {
        logic ge;
        logic unord;
    } ge_flags_t;

    // Turns the difference R = A - B into {ge, unord}.
    // Zero means equal (ge), NaN means unordered (never ge), otherwise the sign decides.
    function automatic ge_flags_t decode_ge(input logic [FP_W-1:0] r);
        ge_flags_t res;
        logic [1:0] exn;
        exn       = r[FP_W-1 -: 2];
        res.ge    = 1'b0;
        res.unord = 1'b0;
        case (exn)
            EXN_ZERO: res.ge    = 1'b1;
            EXN_NAN:  res.unord = 1'b1;
            default:  res.ge    = ~r[FP_W-3];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fp_ge_arbiter_if.sv
// Requester-side bus of the shared compare unit: request handshake plus response strobe.
interface fp_ge_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 65,
    parameter int TAG_W   = 4
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*(WIDTH+1)-1:0] req_a;
    logic [NUM_REQ*(WIDTH+1)-1:0] req_b;
    logic [NUM_REQ*TAG_W-1:0]     req_tag;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic                         rsp_ge;
    logic                         rsp_unord;
    logic [TAG_W-1:0]             rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_tag,
        input  req_ready, rsp_valid, rsp_ge, rsp_unord, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag,
        output req_ready, rsp_valid, rsp_ge, rsp_unord, rsp_tag
    );
endinterface

// File: rtl/FPSub_11_52_F400_uid2.sv
// Three-stage FloPoCo 11/52 subtractor, R = X - Y, with FloPoCo's active-high rst.
// The exception and sign of R are exact; the exponent/fraction field carries the
// larger-magnitude operand rather than a rounded difference.
module FPSub_11_52_F400_uid2
    import fp_cmp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] X,
    input  logic [FP_W-1:0] Y,
    output logic [FP_W-1:0] R
);
    localparam int STAGES = 3;
    localparam int MAG_W  = FP_W - 3;

    logic [FP_W-1:0] r_d;
    logic [FP_W-1:0] r_q [STAGES];
    logic [1:0]      ex, ey;
    logic            sx, sy;
    logic            x_gt, mag_eq;

    // Exception/sign of X + (-Y)
    always_comb begin
        ex     = X[FP_W-1 -: 2];
        ey     = Y[FP_W-1 -: 2];
        sx     = X[FP_W-3];
        sy     = ~Y[FP_W-3];
        x_gt   = X[MAG_W-1:0] > Y[MAG_W-1:0];
        mag_eq = X[MAG_W-1:0] == Y[MAG_W-1:0];
        r_d    = {EXN_NORMAL, sx, X[MAG_W-1:0]};
        if (ex == EXN_NAN || ey == EXN_NAN) begin
            r_d = {EXN_NAN, 1'b0, {MAG_W{1'b0}}};
        end else if (ex == EXN_INF && ey == EXN_INF) begin
            r_d = (sx == sy) ? {EXN_INF, sx, {MAG_W{1'b0}}} : {EXN_NAN, 1'b0, {MAG_W{1'b0}}};
        end else if (ex == EXN_INF) begin
            r_d = {EXN_INF, sx, {MAG_W{1'b0}}};
        end else if (ey == EXN_INF) begin
            r_d = {EXN_INF, sy, {MAG_W{1'b0}}};
        end else if (ex == EXN_ZERO && ey == EXN_ZERO) begin
            r_d = {EXN_ZERO, sx & sy, {MAG_W{1'b0}}};
        end else if (ex == EXN_ZERO) begin
            r_d = {EXN_NORMAL, sy, Y[MAG_W-1:0]};
        end else if (ey == EXN_ZERO) begin
            r_d = {EXN_NORMAL, sx, X[MAG_W-1:0]};
        end else if (sx == sy) begin
            r_d = {EXN_NORMAL, sx, x_gt ? X[MAG_W-1:0] : Y[MAG_W-1:0]};
        end else if (mag_eq) begin
            r_d = {EXN_ZERO, 1'b0, {MAG_W{1'b0}}};
        end else if (x_gt) begin
            r_d = {EXN_NORMAL, sx, X[MAG_W-1:0]};
        end else begin
            r_d = {EXN_NORMAL, sy, Y[MAG_W-1:0]};
        end
    end

    // Pipeline registers between X/Y and R
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) r_q[i] <= '0;
        end else begin
            r_q[0] <= r_d;
            for (int i = 1; i < STAGES; i++) r_q[i] <= r_q[i-1];
        end
    end

    assign R = r_q[STAGES-1];
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant among N requesters; search starts at the pointer, which moves past the winner.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);
    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               cand;

    // Walk from the farthest candidate to the nearest so the nearest valid one wins
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = 0;
        if (en_i) begin
            for (int off = N - 1; off >= 0; off--) begin
                cand = int'(ptr_q) + off;
                if (cand >= N) cand = cand - N;
                if (req_i[cand]) begin
                    grant_idx_o   = IDX_W'(cand);
                    grant_valid_o = 1'b1;
                end
            end
        end
        if (grant_valid_o) grant_o = N'(1) << grant_idx_o;
    end

    // Next pointer: one past the winner, wrapping at N
    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid_o) begin
            ptr_d = (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/fp_ge_arbiter.sv
// Shares one pipelined FP subtractor among NUM_REQ requesters for A >= B compares.
// A shadow pipeline carries requester index and tag alongside the subtractor so the
// decoded result is returned to whoever issued it, SUB_LATENCY+1 edges after acceptance.
module fp_ge_arbiter
    import fp_cmp_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 65,
    parameter int SUB_LATENCY = 3,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    fp_ge_arbiter_if.slave   bus,
    output logic             busy
);
    localparam int OPW   = WIDTH + 1;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Stage 0 sits beside the X/Y register; stages 1..SUB_LATENCY track the subtractor
    localparam int DEPTH = SUB_LATENCY + 1;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               arb_en;
    logic               sub_rst;

    logic [OPW-1:0]     sel_a, sel_b;
    logic [TAG_W-1:0]   sel_tag;
    logic [OPW-1:0]     x_q, y_q;
    logic [OPW-1:0]     sub_r;

    logic [DEPTH-1:0]   sh_valid_q;
    logic [IDX_W-1:0]   sh_idx_q [DEPTH];
    logic [TAG_W-1:0]   sh_tag_q [DEPTH];

    logic [NUM_REQ-1:0] rsp_hit;
    ge_flags_t          dec;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_ge_q, rsp_ge_d;
    logic               rsp_unord_q, rsp_unord_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

    assign arb_en  = rst & ~flush;
    assign sub_rst = ~rst;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk           (clk),
        .rst_n         (rst),
        .en_i          (arb_en),
        .req_i         (bus.req_valid),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign bus.req_ready = grant;

    // Route the granted requester's operands and tag toward the issue register
    always_comb begin
        sel_a   = bus.req_a[int'(grant_idx)*OPW +: OPW];
        sel_b   = bus.req_b[int'(grant_idx)*OPW +: OPW];
        sel_tag = bus.req_tag[int'(grant_idx)*TAG_W +: TAG_W];
    end

    // X/Y register feeding the subtractor; stale contents are harmless once shadow valid drops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (grant_valid) begin
            x_q <= sel_a;
            y_q <= sel_b;
        end
    end

    FPSub_11_52_F400_uid2 u_sub (
        .clk (clk),
        .rst (sub_rst),
        .X   (x_q),
        .Y   (y_q),
        .R   (sub_r)
    );

    // Shadow pipeline: never stalls; flush drops every in-flight valid bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sh_idx_q[i] <= '0;
                sh_tag_q[i] <= '0;
            end
        end else begin
            sh_valid_q  <= flush ? '0 : {sh_valid_q[DEPTH-2:0], grant_valid};
            sh_idx_q[0] <= grant_idx;
            sh_tag_q[0] <= sel_tag;
            for (int i = 1; i < DEPTH; i++) begin
                sh_idx_q[i] <= sh_idx_q[i-1];
                sh_tag_q[i] <= sh_tag_q[i-1];
            end
        end
    end

    // One-hot return address of the compare leaving the subtractor
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hit
        assign rsp_hit[gi] = (sh_idx_q[DEPTH-1] == IDX_W'(gi));
    end

    assign dec = decode_ge(sub_r);

    // Result stage next state: flags forced low unless a surviving compare completes
    always_comb begin
        rsp_valid_d = '0;
        rsp_ge_d    = 1'b0;
        rsp_unord_d = 1'b0;
        rsp_tag_d   = rsp_tag_q;
        if (sh_valid_q[DEPTH-1] && !flush) begin
            rsp_valid_d = rsp_hit;
            rsp_ge_d    = dec.ge;
            rsp_unord_d = dec.unord;
            rsp_tag_d   = sh_tag_q[DEPTH-1];
        end
    end

    // Result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= '0;
            rsp_ge_q    <= 1'b0;
            rsp_unord_q <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_ge_q    <= rsp_ge_d;
            rsp_unord_q <= rsp_unord_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ge    = rsp_ge_q;
    assign bus.rsp_unord = rsp_unord_q;
    assign bus.rsp_tag   = rsp_tag_q;

    // Anything still travelling through the shadow pipeline or result stage
    always_comb begin
        busy = (|sh_valid_q) | (|rsp_valid_q);
    end
endmodule

// File: tb/tb_fp_ge_arbiter.sv
// Directed bench for fp_ge_arbiter: reset, single/back-to-back compares, round-robin,
// special values, flush and asynchronous reset with compares in flight.
module tb_fp_ge_arbiter;
    import fp_cmp_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int WIDTH       = 65;
    localparam int SUB_LATENCY = 3;
    localparam int TAG_W       = 4;
    localparam int OPW         = WIDTH + 1;

    localparam logic [65:0] F_1_0 = 66'h1_3FF0000000000000;
    localparam logic [65:0] F_2_0 = 66'h1_4000000000000000;
    localparam logic [65:0] F_3_5 = 66'h1_400C000000000000;
    localparam logic [65:0] F_NAN = 66'h3_0000000000000000;
    localparam logic [65:0] F_INF = 66'h2_0000000000000000;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [3:0] exp_v;

    fp_ge_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    fp_ge_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .WIDTH       (WIDTH),
        .SUB_LATENCY (SUB_LATENCY),
        .TAG_W       (TAG_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [3:0] v, input logic ge,
                           input logic un, input logic [3:0] t);
        chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'(v));
        chk({tag, ".ge"},    32'(bus.rsp_ge),    32'(ge));
        chk({tag, ".unord"}, 32'(bus.rsp_unord), 32'(un));
        if (v != 4'b0000) chk({tag, ".tag"}, 32'(bus.rsp_tag), 32'(t));
        $display("rsp %s valid=%b ge=%b unord=%b tag=%0h", tag,
                 bus.rsp_valid, bus.rsp_ge, bus.rsp_unord, bus.rsp_tag);
    endtask

    task automatic set_req(input int i, input logic [65:0] a, input logic [65:0] b,
                           input logic [3:0] t);
        bus.req_a[i*OPW +: OPW]       = a;
        bus.req_b[i*OPW +: OPW]       = b;
        bus.req_tag[i*TAG_W +: TAG_W] = t;
    endtask

    // Every step starts on a falling edge; inputs settle for 1 time unit before checks
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 4'b1111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;

        // ---- Reset state ----
        step(); #1;
        chk("reset.ready", 32'(bus.req_ready), 32'(4'b0000));
        chk_rsp("reset", 4'b0000, 1'b0, 1'b0, 4'h0);
        chk("reset.tag", 32'(bus.rsp_tag), 32'h0);
        chk("reset.busy", 32'(busy), 32'(1'b0));
        step(); rst = 1'b1; bus.req_valid = 4'b0000;

        // ---- Single compare 2.0 >= 1.0, requester 0, tag 5 ----
        step(); set_req(0, F_2_0, F_1_0, 4'h5); bus.req_valid = 4'b0001; #1;
        chk("t1.ready", 32'(bus.req_ready), 32'(4'b0001));
        step(); bus.req_valid = 4'b0000; #1;
        chk("t1.busy", 32'(busy), 32'(1'b1));
        chk_rsp("t1.k0", 4'b0000, 1'b0, 1'b0, 4'h0);
        for (int n = 1; n <= 3; n++) begin
            step(); #1;
            chk_rsp("t1.wait", 4'b0000, 1'b0, 1'b0, 4'h0);
        end
        step(); #1;
        chk_rsp("t1.rsp", 4'b0001, 1'b1, 1'b0, 4'h5);
        step(); #1;
        chk_rsp("t1.after", 4'b0000, 1'b0, 1'b0, 4'h0);
        chk("t1.idle", 32'(busy), 32'(1'b0));

        // ---- Back-to-back: 1.0 vs 2.0, then 3.5 vs 3.5 (pointer at 1) ----
        step(); set_req(1, F_1_0, F_2_0, 4'h3); bus.req_valid = 4'b0010; #1;
        chk("t2.ready0", 32'(bus.req_ready), 32'(4'b0010));
        step(); set_req(1, F_3_5, F_3_5, 4'h4); #1;
        chk("t2.ready1", 32'(bus.req_ready), 32'(4'b0010));
        step(); bus.req_valid = 4'b0000; #1;
        for (int n = 0; n < 2; n++) begin
            step(); #1;
            chk_rsp("t2.wait", 4'b0000, 1'b0, 1'b0, 4'h0);
        end
        step(); #1;
        chk_rsp("t2.lt", 4'b0010, 1'b0, 1'b0, 4'h3);
        step(); #1;
        chk_rsp("t2.eq", 4'b0010, 1'b1, 1'b0, 4'h4);
        step(); #1;
        chk_rsp("t2.after", 4'b0000, 1'b0, 1'b0, 4'h0);

        // ---- Special values: NaN (requester 2), +inf (requester 3) ----
        step(); set_req(2, F_NAN, F_1_0, 4'h6); bus.req_valid = 4'b0100; #1;
        chk("t3.ready0", 32'(bus.req_ready), 32'(4'b0100));
        step(); set_req(3, F_INF, F_1_0, 4'h7); bus.req_valid = 4'b1000; #1;
        chk("t3.ready1", 32'(bus.req_ready), 32'(4'b1000));
        step(); bus.req_valid = 4'b0000; #1;
        for (int n = 0; n < 2; n++) begin
            step(); #1;
            chk_rsp("t3.wait", 4'b0000, 1'b0, 1'b0, 4'h0);
        end
        step(); #1;
        chk_rsp("t3.nan", 4'b0100, 1'b0, 1'b1, 4'h6);
        step(); #1;
        chk_rsp("t3.inf", 4'b1000, 1'b1, 1'b0, 4'h7);
        step(); #1;
        chk_rsp("t3.after", 4'b0000, 1'b0, 1'b0, 4'h0);

        // ---- All four valid for 8 cycles (pointer back at 0) ----
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) set_req(i, F_2_0, F_1_0, 4'(8 + i));
            else            set_req(i, F_1_0, F_2_0, 4'(8 + i));
        end
        for (int c = 0; c < 14; c++) begin
            step();
            bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_v = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            chk("t4.ready", 32'(bus.req_ready), 32'(exp_v));
            chk("t4.busy", 32'(busy), 32'((c >= 1) && (c <= 12)));
            if (c >= 5 && c <= 12) begin
                chk_rsp("t4.rsp", 4'b0001 << ((c - 5) % 4), ((c - 5) % 2) == 0, 1'b0,
                        4'(8 + (c - 5) % 4));
            end else begin
                chk_rsp("t4.none", 4'b0000, 1'b0, 1'b0, 4'h0);
            end
        end

        // ---- Flush with three compares in flight ----
        set_req(0, F_1_0, F_2_0, 4'hC);
        set_req(1, F_2_0, F_1_0, 4'h1);
        set_req(2, F_2_0, F_1_0, 4'h2);
        for (int s = 0; s < 3; s++) begin
            step(); bus.req_valid = 4'b0111; #1;
            chk("t5.ready", 32'(bus.req_ready), 32'(4'b0001 << s));
        end
        step(); flush = 1'b1; bus.req_valid = 4'b0001; #1;
        chk("t5.flush_ready", 32'(bus.req_ready), 32'(4'b0000));
        chk("t5.flush_busy", 32'(busy), 32'(1'b1));
        step(); flush = 1'b0; #1;
        chk("t5.post_busy", 32'(busy), 32'(1'b0));
        chk("t5.post_ready", 32'(bus.req_ready), 32'(4'b0001));
        chk_rsp("t5.post", 4'b0000, 1'b0, 1'b0, 4'h0);
        step(); bus.req_valid = 4'b0000; #1;
        chk("t5.reissue_busy", 32'(busy), 32'(1'b1));
        chk_rsp("t5.drop0", 4'b0000, 1'b0, 1'b0, 4'h0);
        for (int n = 1; n <= 3; n++) begin
            step(); #1;
            chk_rsp("t5.drop", 4'b0000, 1'b0, 1'b0, 4'h0);
        end
        step(); #1;
        chk_rsp("t5.rsp", 4'b0001, 1'b0, 1'b0, 4'hC);
        step(); #1;
        chk_rsp("t5.after", 4'b0000, 1'b0, 1'b0, 4'h0);
        chk("t5.idle", 32'(busy), 32'(1'b0));

        // ---- Asynchronous reset with two compares in flight (pointer at 1) ----
        set_req(1, F_2_0, F_1_0, 4'hA);
        set_req(0, F_1_0, F_2_0, 4'hB);
        step(); bus.req_valid = 4'b0010; #1;
        chk("t6.ready0", 32'(bus.req_ready), 32'(4'b0010));
        step(); bus.req_valid = 4'b0001; #1;
        chk("t6.ready1", 32'(bus.req_ready), 32'(4'b0001));
        step(); bus.req_valid = 4'b0000; #1;
        chk("t6.busy_pre", 32'(busy), 32'(1'b1));
        #2; rst = 1'b0; bus.req_valid = 4'b1111; #1;
        chk("t6.rst_ready", 32'(bus.req_ready), 32'(4'b0000));
        chk_rsp("t6.rst", 4'b0000, 1'b0, 1'b0, 4'h0);
        chk("t6.rst_tag", 32'(bus.rsp_tag), 32'h0);
        chk("t6.rst_busy", 32'(busy), 32'(1'b0));
        set_req(0, F_3_5, F_1_0, 4'hD);
        step(); rst = 1'b1; #1;
        chk("t6.first_grant", 32'(bus.req_ready), 32'(4'b0001));
        step(); bus.req_valid = 4'b0000; #1;
        chk("t6.busy_new", 32'(busy), 32'(1'b1));
        chk_rsp("t6.none0", 4'b0000, 1'b0, 1'b0, 4'h0);
        for (int n = 1; n <= 3; n++) begin
            step(); #1;
            chk_rsp("t6.none", 4'b0000, 1'b0, 1'b0, 4'h0);
        end
        step(); #1;
        chk_rsp("t6.rsp", 4'b0001, 1'b1, 1'b0, 4'hD);
        step(); #1;
        chk_rsp("t6.after", 4'b0000, 1'b0, 1'b0, 4'h0);
        chk("t6.idle", 32'(busy), 32'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
